// File: rtl/lc3_mem_responder.sv
// ----------------------------------------------------------------------------
// lc3_mem_responder : LC3 instr/data memory with fixed, programmable latency.
// Optional stall input enabled by defining LC3_MEM_STALL_EN.
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module lc3_mem_responder #(
  parameter logic [15:0] BASE_ADDR  = 16'h3000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          INSTR_LAT  = 1,
  parameter int          DATA_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instrmem_rd,
  input  logic [15:0] pc,
  output logic [15:0] Instr_dout,
  output logic        complete_instr,
  input  logic        Data_en,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  input  logic        load_en,
  input  logic        load_sel,
  input  logic [15:0] load_addr,
  input  logic [15:0] load_data,
  output logic        instr_oob
`ifdef LC3_MEM_STALL_EN
  ,
  input  logic        stall_req
`endif
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] I_LAT = 4'(INSTR_LAT);
  localparam logic [3:0] D_LAT = 4'(DATA_LAT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  logic stall;
`ifdef LC3_MEM_STALL_EN
  assign stall = stall_req;
`else
  assign stall = 1'b0;
`endif

  logic [15:0] imem [DEPTH];
  logic [15:0] dmem [DEPTH];

  state_t                  i_state_q, i_state_d;
  logic [3:0]              i_cnt_q, i_cnt_d;
  logic [15:0]             i_idx_q, i_idx_d;
  logic [15:0]             instr_dout_q, instr_dout_d;
  logic                    instr_oob_q, instr_oob_d;
  logic                    i_hit_oob;

  state_t                  d_state_q, d_state_d;
  logic [3:0]              d_cnt_q, d_cnt_d;
  logic [DEPTH_LOG2-1:0]   d_idx_q, d_idx_d;
  logic [15:0]             d_din_q, d_din_d;
  logic                    d_rd_q, d_rd_d;
  logic [15:0]             data_dout_q, data_dout_d;

  logic w_unused;
  assign w_unused = ^{Data_addr[15:DEPTH_LOG2], load_addr[15:DEPTH_LOG2]};

  // Any index bit at or above DEPTH_LOG2 means the fetch fell off the array.
  assign i_hit_oob = (i_idx_q >> DEPTH_LOG2) != 16'd0;

  always_comb begin
    i_state_d      = i_state_q;
    i_cnt_d        = i_cnt_q;
    i_idx_d        = i_idx_q;
    instr_dout_d   = instr_dout_q;
    instr_oob_d    = instr_oob_q;
    complete_instr = 1'b0;
    case (i_state_q)
      S_IDLE: begin
        if (instrmem_rd) begin
          i_idx_d = pc - BASE_ADDR;
          if (stall) begin
            i_cnt_d   = I_LAT;
            i_state_d = S_WAIT;
          end else begin
            i_cnt_d   = I_LAT - 4'd1;
            i_state_d = (I_LAT == 4'd1) ? S_DONE : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!stall) begin
          if (i_cnt_q <= 4'd1) i_state_d = S_DONE;
          else                 i_cnt_d   = i_cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        complete_instr = 1'b1;
        instr_dout_d   = i_hit_oob ? 16'h0000 : imem[i_idx_q[DEPTH_LOG2-1:0]];
        instr_oob_d    = instr_oob_q | i_hit_oob;
        i_state_d      = S_IDLE;
      end
      default: i_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    d_state_d     = d_state_q;
    d_cnt_d       = d_cnt_q;
    d_idx_d       = d_idx_q;
    d_din_d       = d_din_q;
    d_rd_d        = d_rd_q;
    data_dout_d   = data_dout_q;
    complete_data = 1'b0;
    case (d_state_q)
      S_IDLE: begin
        if (Data_en) begin
          d_idx_d = Data_addr[DEPTH_LOG2-1:0];
          d_din_d = Data_din;
          d_rd_d  = Data_rd;
          if (stall) begin
            d_cnt_d   = D_LAT;
            d_state_d = S_WAIT;
          end else begin
            d_cnt_d   = D_LAT - 4'd1;
            d_state_d = (D_LAT == 4'd1) ? S_DONE : S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!stall) begin
          if (d_cnt_q <= 4'd1) d_state_d = S_DONE;
          else                 d_cnt_d   = d_cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        complete_data = 1'b1;
        if (d_rd_q) data_dout_d = dmem[d_idx_q];
        d_state_d = S_IDLE;
      end
      default: d_state_d = S_IDLE;
    endcase
  end

  // Outputs follow the _d values so the read data is visible in the DONE cycle.
  assign Instr_dout = instr_dout_d;
  assign Data_dout  = data_dout_d;
  assign instr_oob  = instr_oob_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_state_q    <= S_IDLE;
      i_cnt_q      <= 4'd0;
      i_idx_q      <= 16'd0;
      instr_dout_q <= 16'd0;
      instr_oob_q  <= 1'b0;
      d_state_q    <= S_IDLE;
      d_cnt_q      <= 4'd0;
      d_idx_q      <= '0;
      d_din_q      <= 16'd0;
      d_rd_q       <= 1'b0;
      data_dout_q  <= 16'd0;
    end else begin
      i_state_q    <= i_state_d;
      i_cnt_q      <= i_cnt_d;
      i_idx_q      <= i_idx_d;
      instr_dout_q <= instr_dout_d;
      instr_oob_q  <= instr_oob_d;
      d_state_q    <= d_state_d;
      d_cnt_q      <= d_cnt_d;
      d_idx_q      <= d_idx_d;
      d_din_q      <= d_din_d;
      d_rd_q       <= d_rd_d;
      data_dout_q  <= data_dout_d;
    end
  end

  // Arrays are never cleared; the backdoor load is written last so it wins a collision.
  always_ff @(posedge clk) begin
    if (d_state_q == S_DONE && !d_rd_q)
      dmem[d_idx_q] <= d_din_q;
    if (load_en && load_sel)
      dmem[load_addr[DEPTH_LOG2-1:0]] <= load_data;
    if (load_en && !load_sel)
      imem[load_addr[DEPTH_LOG2-1:0]] <= load_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_lc3_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_lc3_mem_responder : scoreboard bench for lc3_mem_responder (default params).
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lc3_mem_responder;

  localparam int INSTR_LAT = 1;
  localparam int DATA_LAT  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instrmem_rd = 1'b0;
  logic [15:0] pc = 16'h0;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        Data_en = 1'b0;
  logic        Data_rd = 1'b0;
  logic [15:0] Data_addr = 16'h0;
  logic [15:0] Data_din = 16'h0;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        load_en = 1'b0;
  logic        load_sel = 1'b0;
  logic [15:0] load_addr = 16'h0;
  logic [15:0] load_data = 16'h0;
  logic        instr_oob;

  lc3_mem_responder #(
    .BASE_ADDR(16'h3000), .DEPTH_LOG2(10), .INSTR_LAT(INSTR_LAT), .DATA_LAT(DATA_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .instrmem_rd(instrmem_rd), .pc(pc), .Instr_dout(Instr_dout), .complete_instr(complete_instr),
    .Data_en(Data_en), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_dout(Data_dout), .complete_data(complete_data),
    .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
    .instr_oob(instr_oob)
`ifdef LC3_MEM_STALL_EN
    , .stall_req(1'b0)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {int cyc; logic [15:0] val;} exp_t;
  exp_t iq[$];
  exp_t dq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every completion pulse must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (complete_instr) begin
      checks++;
      if (iq.size() == 0) begin
        errors++;
        $display("FAIL instr_unexpected: pulse at cycle %0d dout %h, none expected", cyc, Instr_dout);
      end else begin
        e = iq.pop_front();
        if (e.cyc != cyc || Instr_dout !== e.val) begin
          errors++;
          $display("FAIL instr_resp: got cycle %0d dout %h, expected cycle %0d dout %h",
                   cyc, Instr_dout, e.cyc, e.val);
        end
      end
    end
    if (complete_data) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL data_unexpected: pulse at cycle %0d dout %h, none expected", cyc, Data_dout);
      end else begin
        e = dq.pop_front();
        if (e.cyc != cyc || Data_dout !== e.val) begin
          errors++;
          $display("FAIL data_resp: got cycle %0d dout %h, expected cycle %0d dout %h",
                   cyc, Data_dout, e.cyc, e.val);
        end
      end
    end
  end

  task automatic load(input logic sel, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    load_en = 1'b1; load_sel = sel; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] a, input logic [15:0] ev);
    @(negedge clk);
    instrmem_rd = 1'b1; pc = a;
    iq.push_back('{cyc + INSTR_LAT, ev});
    @(negedge clk);
    instrmem_rd = 1'b0;
    repeat (INSTR_LAT + 1) @(negedge clk);
  endtask

  // ev is the Data_dout expected at completion (old value for a write).
  task automatic dacc(input logic rd, input logic [15:0] a, input logic [15:0] din,
                      input logic [15:0] ev);
    @(negedge clk);
    Data_en = 1'b1; Data_rd = rd; Data_addr = a; Data_din = din;
    dq.push_back('{cyc + DATA_LAT, ev});
    @(negedge clk);
    Data_en = 1'b0;
    repeat (DATA_LAT + 1) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle outputs
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_instr_dout", Instr_dout, 16'h0);
    check("rst_data_dout", Data_dout, 16'h0);
    check("rst_complete_instr", {15'd0, complete_instr}, 16'h0);
    check("rst_complete_data", {15'd0, complete_data}, 16'h0);
    check("rst_instr_oob", {15'd0, instr_oob}, 16'h0);
    repeat (3) @(negedge clk);

    // Instruction fetch, latency 1
    load(1'b0, 16'd0, 16'h1261);
    load(1'b0, 16'd1, 16'hABCD);
    fetch(16'h3000, 16'h1261);
    fetch(16'h3001, 16'hABCD);

    // Held request: accepted, ignored in DONE, re-accepted one cycle later
    @(negedge clk);
    instrmem_rd = 1'b1; pc = 16'h3000;
    iq.push_back('{cyc + INSTR_LAT, 16'h1261});
    iq.push_back('{cyc + 2 * INSTR_LAT + 1, 16'h1261});
    repeat (2 * INSTR_LAT + 1) @(negedge clk);
    instrmem_rd = 1'b0;
    repeat (3) @(negedge clk);

    // Data write then read, aliasing of high address bits
    dacc(1'b0, 16'h0005, 16'hBEEF, 16'h0000);
    dacc(1'b1, 16'h0005, 16'h0000, 16'hBEEF);
    dacc(1'b0, 16'h0405, 16'h1234, 16'hBEEF);
    dacc(1'b1, 16'h0005, 16'h0000, 16'h1234);

    // Backdoor load collides with DONE-cycle write: load wins
    @(negedge clk);
    Data_en = 1'b1; Data_rd = 1'b0; Data_addr = 16'd9; Data_din = 16'h1111;
    dq.push_back('{cyc + DATA_LAT, 16'h1234});
    @(negedge clk);
    Data_en = 1'b0;
    repeat (DATA_LAT - 1) @(negedge clk);
    load_en = 1'b1; load_sel = 1'b1; load_addr = 16'd9; load_data = 16'h2222;
    @(negedge clk);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    dacc(1'b1, 16'd9, 16'h0, 16'h2222);

    // Backdoor load collides with DONE-cycle read: read sees old value
    load(1'b1, 16'd10, 16'h0A0A);
    @(negedge clk);
    Data_en = 1'b1; Data_rd = 1'b1; Data_addr = 16'd10;
    dq.push_back('{cyc + DATA_LAT, 16'h0A0A});
    @(negedge clk);
    Data_en = 1'b0;
    repeat (DATA_LAT - 1) @(negedge clk);
    load_en = 1'b1; load_sel = 1'b1; load_addr = 16'd10; load_data = 16'h5555;
    @(negedge clk);
    load_en = 1'b0;
    repeat (2) @(negedge clk);
    dacc(1'b1, 16'd10, 16'h0, 16'h5555);

    // Out-of-range fetch returns 0 and sets the sticky flag
    check("oob_before", {15'd0, instr_oob}, 16'h0);
    fetch(16'h3400, 16'h0000);
    check("oob_set", {15'd0, instr_oob}, 16'h1);
    fetch(16'h3001, 16'hABCD);
    check("oob_sticky", {15'd0, instr_oob}, 16'h1);
    fetch(16'h2FFF, 16'h0000);

    // Reset during a pending write: dropped, memory untouched
    load(1'b1, 16'd7, 16'h0042);
    @(negedge clk);
    Data_en = 1'b1; Data_rd = 1'b0; Data_addr = 16'd7; Data_din = 16'h9999;
    @(negedge clk);
    Data_en = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst2_data_dout", Data_dout, 16'h0);
    check("rst2_instr_oob", {15'd0, instr_oob}, 16'h0);
    dacc(1'b1, 16'd7, 16'h0, 16'h0042);
    fetch(16'h3000, 16'h1261);

    repeat (5) @(negedge clk);
    checks++;
    if (iq.size() != 0) begin
      errors++;
      $display("FAIL instr_pending: got %0d outstanding fetches, expected 0", iq.size());
    end
    checks++;
    if (dq.size() != 0) begin
      errors++;
      $display("FAIL data_pending: got %0d outstanding data accesses, expected 0", dq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
